div_iter: RTL and testbench

//  Multi-cycle 32-bit integer divider for DIV/DIVU in the execute stage; the EX-stage

---
 rtl/div_iter.sv | 124 ++++++++++++
 tb/tb_div_iter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Purpose : multi-cycle restoring divider for DIV/DIVU, result goes to the HI (rem) / LO (quo) write port.
// Latency : res_valid rises WIDTH+1 edges after the start edge (WIDTH RUN steps plus one sign-fix edge).
// Backpres: result held in DONE until res_ready; no new start accepted until the handoff completes.
//
// Ports:
//   clk, resetn            rising-edge clock, asynchronous active-low reset
//   flush                  synchronous abort, beats every other input
//   div_valid/div_ready    start handshake (div_ready only in IDLE)
//   div_signed             1 = DIV (two's complement), 0 = DIVU
//   div_a, div_b           dividend, divisor
//   res_valid/res_ready    result handshake
//   res_quo, res_rem       quotient (LO), remainder (HI); hold their value after handoff
//   busy                   unit not idle, used for the HI/LO hazard stall
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_quo,
  output logic [WIDTH-1:0] res_rem,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;      // holds the dividend, shifted out MSB-first as quotient bits shift in
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;

  assign abs_a = (div_signed && div_a[WIDTH-1]) ? -div_a : div_a;
  assign abs_b = (div_signed && div_b[WIDTH-1]) ? -div_b : div_b;

  // The partial remainder is always below 2^(WIDTH-1) before a shift (it is a
  // prefix of at most WIDTH-1 dividend bits), so dropping rem's MSB loses nothing.
  assign shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {1'b0, dvsr};
  assign borrow  = diff[WIDTH];

  assign busy      = (state != ST_IDLE);
  assign div_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      res_valid <= 1'b0;
      res_quo   <= '0;
      res_rem   <= '0;
    end else if (flush) begin
      // Abort wins over start, stepping and handoff; res_quo/res_rem are left alone.
      state     <= ST_IDLE;
      cnt       <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_valid) begin
            state  <= ST_RUN;
            quo    <= abs_a;
            dvsr   <= abs_b;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= div_signed & (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
            sign_r <= div_signed & div_a[WIDTH-1];
          end
        end
        ST_RUN: begin
          rem <= borrow ? shifted : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~borrow};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          // Divide-by-zero and 0x80000000/-1 fall out of the magnitude result naturally.
          res_quo   <= sign_q ? -quo : quo;
          res_rem   <= sign_r ? -rem : rem;
          res_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_signed = 1'b0;
  logic        res_ready = 1'b0;
  logic [31:0] div_a = '0;
  logic [31:0] div_b = '0;
  logic        div_ready;
  logic        res_valid;
  logic        busy;
  logic [31:0] res_quo;
  logic [31:0] res_rem;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_quo    (res_quo),
    .res_rem    (res_rem),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: magnitude division, divide-by-zero gives all-ones / |a|, then sign fix.
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    ua = (s && a[31]) ? (32'd0 - a) : a;
    ub = (s && b[31]) ? (32'd0 - b) : b;
    if (ub == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (s && (a[31] ^ b[31])) q = 32'd0 - q;
    if (s && a[31]) r = 32'd0 - r;
    return {q, r};
  endfunction

  // Entered and left at a falling edge; the start edge is the rising edge in between.
  task automatic start(input bit s, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!div_ready) check("start_timeout", {63'd0, div_ready}, 64'd1);
    div_signed = s;
    div_a      = a;
    div_b      = b;
    div_valid  = 1'b1;
    @(negedge clk);
    div_valid  = 1'b0;
  endtask

  // Counts rising edges after the start edge until res_valid is seen.
  task automatic wait_res(output int k);
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid) check("res_timeout", {63'd0, res_valid}, 64'd1);
  endtask

  task automatic take(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {res_quo, res_rem}, e);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int k;
    bit seen;
    bit s;
    logic [31:0] a, b;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outs", {res_valid, busy, div_ready}, 64'b001);
    check("rst_res", {res_quo, res_rem}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // DIVU 100/7 with exact latency
    exp_q.push_back({32'h0000_000E, 32'h0000_0002});
    start(1'b0, 32'd100, 32'd7);
    check("busy_run", {busy, div_ready}, 64'b10);
    wait_res(k);
    check("lat_divu", k, 33);
    take("divu_100_7");
    check("idle_after", {res_valid, busy, div_ready}, 64'b001);

    // Signed cases and boundaries
    exp_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
    start(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_res(k);
    take("div_m7_2");

    exp_q.push_back({32'hFFFF_FFFD, 32'h0000_0001});
    start(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_res(k);
    take("div_7_m2");

    exp_q.push_back({32'h8000_0000, 32'h0000_0000});
    start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_res(k);
    take("div_ovf");

    exp_q.push_back({32'hFFFF_FFFF, 32'h0000_0005});
    start(1'b0, 32'd5, 32'd0);
    wait_res(k);
    take("divu_5_0");

    // Hold in DONE for 10 cycles
    start(1'b0, 32'd1000, 32'd33);
    wait_res(k);
    for (int i = 0; i < 10; i++) begin
      check("hold_ctl", {res_valid, busy, div_ready}, 64'b110);
      check("hold_dat", {res_quo, res_rem}, {32'd30, 32'd10});
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("hold_release", {res_valid, busy, div_ready}, 64'b001);
    check("res_persist", {res_quo, res_rem}, {32'd30, 32'd10});

    // Flush at RUN iteration 10
    start(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {res_valid, busy, div_ready}, 64'b001);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= res_valid;
      @(negedge clk);
    end
    check("flush_no_res", {63'd0, seen}, 64'd0);

    // flush together with div_valid: no start
    div_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    flush     = 1'b0;
    check("flush_vs_start", {busy, div_ready}, 64'b01);

    exp_q.push_back({32'd3, 32'd0});
    start(1'b0, 32'd9, 32'd3);
    wait_res(k);
    take("divu_9_3");

    // flush in DONE with res_ready: flush wins, back to IDLE
    start(1'b0, 32'd50, 32'd5);
    wait_res(k);
    flush     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    res_ready = 1'b0;
    check("flush_done", {res_valid, busy, div_ready}, 64'b001);

    // Asynchronous reset mid-RUN
    start(1'b1, 32'hFFFF_FF9C, 32'd7);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_ctl", {res_valid, busy, div_ready}, 64'b001);
    check("arst_res", {res_quo, res_rem}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("arst_release", {busy, div_ready}, 64'b01);

    // Randomised operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      exp_q.push_back(model(s, a, b));
      start(s, a, b);
      wait_res(k);
      check("rand_lat", k, 33);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      take("rand");
    end
    check("sb_drained", exp_q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
